// File: rtl/kbest_level_sched_pkg.sv
// Shared types and widths for the K-best level sequencer and its output stage.
// ERR_WL comes from the shared parameters include; it falls back to 12 when that include is absent.
`ifndef ERR_WL
`define ERR_WL 12
`endif

package kbest_level_sched_pkg;
    localparam int ERR_WL = `ERR_WL;
    localparam int K      = 4;
    localparam int LVL_W  = 3;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_SORT   = 2'd2,
        ST_DONE   = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic [1:0]        idx;
        logic [ERR_WL-1:0] ped;
    } best_t;
endpackage

// File: rtl/kbest_argmin4.sv
// Combinational 4-way unsigned minimum; ties resolve to the lower slot index.
module kbest_argmin4
    import kbest_level_sched_pkg::*;
(
    input  logic [K-1:0][ERR_WL-1:0] ped,
    output logic [1:0]               idx,
    output logic [ERR_WL-1:0]        ped_min
);
    logic [1:0][ERR_WL-1:0] semi_ped;
    logic [1:0]             semi_sel;
    logic                   fin_sel;

    // Strict less-than keeps the lower index of each pair on a tie.
    for (genvar g = 0; g < 2; g++) begin : g_semi
        assign semi_sel[g] = ped[2*g+1] < ped[2*g];
        assign semi_ped[g] = semi_sel[g] ? ped[2*g+1] : ped[2*g];
    end

    assign fin_sel = semi_ped[1] < semi_ped[0];
    assign idx     = fin_sel ? {1'b1, semi_sel[1]} : {1'b0, semi_sel[0]};
    assign ped_min = fin_sel ? semi_ped[1] : semi_ped[0];
endmodule

// File: rtl/kbest_level_sched.sv
// Level sequencer for the K=4 best-first MIMO tree search: walks levels NLEV-1..0 over one enumerator.
// Optional KBEST_PERF_CNT_EN adds the frame_cycles performance counter.
module kbest_level_sched
    import kbest_level_sched_pkg::*;
#(
    parameter int NLEV     = 4,
    parameter int ENUM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic                  flush,
    output logic                  exp_req,
    output logic                  exp_root,
    input  logic                  exp_ack,
    output logic [LVL_W-1:0]      lvl,
    output logic                  cap_en,
    input  logic [K*ERR_WL-1:0]   enum_ped,
    output logic                  done_valid,
    input  logic                  done_ready,
    output logic [1:0]            best_idx,
    output logic [ERR_WL-1:0]     best_ped
`ifdef KBEST_PERF_CNT_EN
    ,
    output logic [15:0]           frame_cycles
`endif
);
    localparam logic [LVL_W-1:0] LVL_TOP  = LVL_W'(NLEV - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ENUM_LAT - 1);

    sched_state_t              state;
    logic [CNT_W-1:0]          cnt;
    best_t                     best;
    logic [K-1:0][ERR_WL-1:0]  ped_w;
    logic [1:0]                am_idx;
    logic [ERR_WL-1:0]         am_ped;

    assign ped_w = enum_ped;

    kbest_argmin4 u_argmin (
        .ped     (ped_w),
        .idx     (am_idx),
        .ped_min (am_ped)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            lvl   <= LVL_TOP;
            cnt   <= '0;
            best  <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
            lvl   <= LVL_TOP;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_valid) begin
                        state <= ST_EXPAND;
                        lvl   <= LVL_TOP;
                    end
                end
                ST_EXPAND: begin
                    if (exp_ack) begin
                        cnt   <= CNT_LOAD;
                        state <= ST_SORT;
                    end
                end
                ST_SORT: begin
                    // cnt==0 is the capture cycle, ENUM_LAT cycles after the ack.
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (lvl != '0) begin
                        lvl   <= lvl - 1'b1;
                        state <= ST_EXPAND;
                    end else begin
                        best  <= '{idx: am_idx, ped: am_ped};
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (done_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign start_ready = state == ST_IDLE;
    assign exp_req     = state == ST_EXPAND;
    assign exp_root    = exp_req && (lvl == LVL_TOP);
    assign cap_en      = (state == ST_SORT) && (cnt == '0);
    assign done_valid  = state == ST_DONE;
    assign best_idx    = best.idx;
    assign best_ped    = best.ped;

`ifdef KBEST_PERF_CNT_EN
    // Starts at 1 so the start-handshake edge itself is counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            frame_cycles <= '0;
        else if (flush)
            frame_cycles <= '0;
        else if (state == ST_IDLE && start_valid)
            frame_cycles <= 16'd1;
        else if ((state == ST_EXPAND || state == ST_SORT) && frame_cycles != 16'hFFFF)
            frame_cycles <= frame_cycles + 16'd1;
    end
`endif
endmodule

// File: tb/tb_kbest_level_sched.sv
// Bench for kbest_level_sched: two instances (ENUM_LAT 1 and 3) against a transaction-level frame model.
`timescale 1ns/1ps
module tb_kbest_level_sched;
    import kbest_level_sched_pkg::*;
    localparam int W = ERR_WL;

    typedef struct {
        bit             active;
        bit             waiting;
        bit             have;
        int             level;
        int             cap_at;
        int             cyc;
        logic [1:0]     idx;
        logic [W-1:0]   bped;
        int             perf;
    } mdl_t;

    logic clk = 0, rst = 1, start_valid = 0, flush = 0, done_ready = 0;
    logic ack [2];
    logic [4*W-1:0] ped = '0;
    logic sr [2], er [2], root [2], cap [2], dv [2];
    logic [2:0] lv [2];
    logic [1:0] bi [2];
    logic [W-1:0] bp [2];
`ifdef KBEST_PERF_CNT_EN
    logic [15:0] fc [2];
`endif

    int vecs = 0, errs = 0;
    int tst = 0, dcyc = 0, ackmode = 1;
    bit stray = 0, tmo = 0;
    int rq [2], tgt [2];
    mdl_t m [2];

    always #5 clk = ~clk;

    kbest_level_sched #(.NLEV(4), .ENUM_LAT(1)) dut0 (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(sr[0]), .flush(flush),
        .exp_req(er[0]), .exp_root(root[0]), .exp_ack(ack[0]), .lvl(lv[0]), .cap_en(cap[0]),
        .enum_ped(ped), .done_valid(dv[0]), .done_ready(done_ready), .best_idx(bi[0]), .best_ped(bp[0])
`ifdef KBEST_PERF_CNT_EN
        , .frame_cycles(fc[0])
`endif
    );

    kbest_level_sched #(.NLEV(4), .ENUM_LAT(3)) dut1 (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(sr[1]), .flush(flush),
        .exp_req(er[1]), .exp_root(root[1]), .exp_ack(ack[1]), .lvl(lv[1]), .cap_en(cap[1]),
        .enum_ped(ped), .done_valid(dv[1]), .done_ready(done_ready), .best_idx(bi[1]), .best_ped(bp[1])
`ifdef KBEST_PERF_CNT_EN
        , .frame_cycles(fc[1])
`endif
    );

    function automatic mdl_t mreset(int nl);
        mdl_t n;
        n.active = 0; n.waiting = 0; n.have = 0; n.level = nl - 1; n.cap_at = -1;
        n.cyc = 0; n.idx = '0; n.bped = '0; n.perf = 0;
        return n;
    endfunction

    // One clock of the frame-level behaviour: a frame is a list of levels, each an ack then a capture el cycles later.
    function automatic mdl_t mstep(mdl_t s, int nl, int el, bit sv, bit fl, bit ak, bit drd,
                                   logic [4*W-1:0] p);
        mdl_t n = s;
        int b = 0;
        n.cyc = s.cyc + 1;
        if (fl) begin
            n.active = 0; n.waiting = 0; n.have = 0; n.level = nl - 1; n.cap_at = -1; n.perf = 0;
        end else if (s.have) begin
            if (drd) n.have = 0;
        end else if (!s.active) begin
            if (sv) begin n.active = 1; n.waiting = 1; n.level = nl - 1; n.perf = 1; end
        end else begin
            if (s.perf < 65535) n.perf = s.perf + 1;
            if (s.waiting) begin
                if (ak) begin n.waiting = 0; n.cap_at = s.cyc + el; end
            end else if (s.cap_at == s.cyc) begin
                n.cap_at = -1;
                if (s.level > 0) begin
                    n.level = s.level - 1; n.waiting = 1;
                end else begin
                    for (int k = 1; k < 4; k++) if (p[k*W +: W] < p[b*W +: W]) b = k;
                    n.idx = 2'(b); n.bped = p[b*W +: W];
                    n.active = 0; n.have = 1;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m[0] <= mreset(4);
            m[1] <= mreset(4);
        end else begin
            m[0] <= mstep(m[0], 4, 1, start_valid, flush, ack[0], done_ready, ped);
            m[1] <= mstep(m[1], 4, 3, start_valid, flush, ack[1], done_ready, ped);
        end
    end

    task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] ex);
        vecs++;
        if (act !== ex) begin
            errs++;
            $display("FAIL %s[%0d]: got %0d expected %0d at %0t", nm, i, act, ex, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk("start_ready", i, sr[i], !m[i].active && !m[i].have);
            chk("exp_req", i, er[i], m[i].active && m[i].waiting);
            chk("exp_root", i, root[i], m[i].active && m[i].waiting && m[i].level == 3);
            chk("cap_en", i, cap[i], m[i].active && !m[i].waiting && m[i].cap_at == m[i].cyc);
            chk("done_valid", i, dv[i], m[i].have);
            chk("lvl", i, lv[i], m[i].level);
            chk("best_idx", i, bi[i], m[i].idx);
            chk("best_ped", i, bp[i], m[i].bped);
`ifdef KBEST_PERF_CNT_EN
            chk("frame_cycles", i, fc[i], m[i].perf);
`endif
        end
        chk("wait_timeout", 0, tmo, 0);
        case (tst)
            1: begin
                chk("t1_cap", 0, cap[0], dcyc == 3 || dcyc == 6 || dcyc == 9 || dcyc == 12);
                chk("t1_cap", 1, cap[1], dcyc == 5 || dcyc == 10 || dcyc == 15 || dcyc == 20);
                if (dcyc == 1) begin chk("t1_lvl3", 0, lv[0], 3); chk("t1_root", 0, root[0], 1); end
                if (dcyc == 4) begin chk("t1_lvl2", 0, lv[0], 2); chk("t1_noroot", 0, root[0], 0); end
                if (dcyc == 10) chk("t1_lvl0", 0, lv[0], 0);
                if (dcyc == 12) chk("t1_notdone", 0, dv[0], 0);
                if (dcyc == 13) begin
                    chk("t1_done", 0, dv[0], 1); chk("t1_idx", 0, bi[0], 1); chk("t1_ped", 0, bp[0], 12);
`ifdef KBEST_PERF_CNT_EN
                    chk("t1_cycles", 0, fc[0], 13);
`endif
                end
                if (dcyc == 21) begin
                    chk("t3_done", 1, dv[1], 1); chk("t3_idx", 1, bi[1], 1); chk("t3_ped", 1, bp[1], 12);
`ifdef KBEST_PERF_CNT_EN
                    chk("t3_cycles", 1, fc[1], 21);
`endif
                end
                if (dcyc == 24) begin
                    chk("t5_nostart", 0, sr[0], 0); chk("t5_nostart", 1, sr[1], 0);
                    chk("t5_hold_dv", 0, dv[0], 1); chk("t5_hold_ped", 0, bp[0], 12);
                end
            end
            2: begin
                if (dcyc == 13) begin chk("t2_tie_idx", 0, bi[0], 0); chk("t2_tie_ped", 0, bp[0], 7); end
                if (dcyc == 21) chk("t2_tie_idx", 1, bi[1], 0);
            end
            3: if (dcyc == 1) begin
                chk("t4_idle", 0, sr[0], 1); chk("t4_nocap", 0, cap[0], 0); chk("t4_nodone", 0, dv[0], 0);
                chk("t4_idle", 1, sr[1], 1); chk("t4_lvl", 0, lv[0], 3);
            end
            4: begin
                chk("t6_rst_ready", 0, sr[0], 1); chk("t6_rst_req", 0, er[0], 0);
                chk("t6_rst_lvl", 0, lv[0], 3); chk("t6_rst_idx", 0, bi[0], 0); chk("t6_rst_ped", 0, bp[0], 0);
            end
            default: ;
        endcase
    end

    // Advance one cycle; inputs change 1ns after the edge, the ack responder runs first.
    task automatic step();
        @(posedge clk);
        #1;
        dcyc++;
        for (int i = 0; i < 2; i++) begin
            logic a;
            a = 0;
            if (er[i]) begin
                if (ackmode != 0 && rq[i] == tgt[i]) a = 1;
                rq[i]++;
            end else begin
                rq[i] = 0;
                tgt[i] = (ackmode == 2) ? int'($urandom_range(1, 3)) : 1;
            end
            if (stray && $urandom_range(0, 9) == 0) a = 1;
            ack[i] = a;
        end
    endtask

    task automatic wait_for(input int which, input int budget);
        int n = 0;
        while (!((which == 0 && cap[0] && lv[0] == 2) || (which == 1 && dv[1]) ||
                 (which == 2 && er[0])) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) tmo = 1;
    endtask

    initial begin
        ack[0] = 0; ack[1] = 0; rq[0] = 0; rq[1] = 0; tgt[0] = 1; tgt[1] = 1;
        #1 rst = 0;
        repeat (3) step();
        rst = 1;
        repeat (2) step();

        // Nominal frame, tie-breaking PED set, then DONE backpressure with start held.
        ackmode = 1; stray = 0;
        ped = {12'(90), 12'(12), 12'(12), 12'(40)};
        step(); tst = 1; dcyc = 0; start_valid = 1;
        step(); start_valid = 0;
        while (dcyc < 14) step();
        start_valid = 1;
        while (dcyc < 26) step();
        start_valid = 0; done_ready = 1;
        step(); done_ready = 0; tst = 0;
        step();

        // All-equal PEDs.
        ped = {12'(7), 12'(7), 12'(7), 12'(7)};
        step(); tst = 2; dcyc = 0; start_valid = 1;
        step(); start_valid = 0;
        while (dcyc < 14) step();
        done_ready = 1;
        while (dcyc < 24) step();
        done_ready = 0; tst = 0;
        step();

        // Flush during capture at level 2, colliding with ack, start and done_ready.
        start_valid = 1;
        step(); start_valid = 0;
        wait_for(0, 40);
        flush = 1; start_valid = 1; done_ready = 1; ack[0] = 1; ack[1] = 1; tst = 3; dcyc = 0;
        step(); flush = 0; start_valid = 0; done_ready = 0;
        step(); tst = 0; start_valid = 1;
        step(); start_valid = 0;
        wait_for(1, 60);
        done_ready = 1;
        repeat (2) step();
        done_ready = 0;

        // Async reset mid-EXPAND with an ack pulse while reset is low.
        ackmode = 0; start_valid = 1;
        step(); start_valid = 0;
        wait_for(2, 10);
        rst = 0; ack[0] = 1; ack[1] = 1; tst = 4;
        step(); ack[0] = 1; ack[1] = 1;
        step(); ack[0] = 0; ack[1] = 0; rst = 1; tst = 0; ackmode = 1;
        repeat (5) step();

        // Randomized traffic with stray acks, random ack delay, flushes and backpressure.
        ackmode = 2; stray = 1;
        for (int c = 0; c < 3000; c++) begin
            step();
            start_valid = $urandom_range(0, 1);
            done_ready  = $urandom_range(0, 2) != 0;
            flush       = $urandom_range(0, 59) == 0;
            for (int k = 0; k < 4; k++)
                ped[k*W +: W] = $urandom_range(0, 1) ? W'($urandom_range(0, 7)) : W'($urandom);
        end
        flush = 0; start_valid = 0;
        step();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
